// File: rtl/hd_scoreboard_if.sv
// Bundles the stimulus-side inputs and verdict-side outputs of the Hamming chain scoreboard.
// The master side drives reference/DUT words and control pulses; the slave side is the checker.
interface hd_scoreboard_if #(
    parameter int K     = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic             eot;
    logic [K-1:0]     exp_data;
    logic             exp_vld;
    logic [K-1:0]     dut_data;
    logic             dut_vld;

    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] cmp_cnt;
    logic [CNT_W-1:0] mis_cnt;
    logic [CNT_W-1:0] vmis_cnt;
    logic [CNT_W-1:0] first_idx;
    logic [K-1:0]     first_exp;
    logic [K-1:0]     first_dut;

    modport master (
        output start, eot, exp_data, exp_vld, dut_data, dut_vld,
        input  busy, done, pass, cmp_cnt, mis_cnt, vmis_cnt,
               first_idx, first_exp, first_dut
    );

    modport slave (
        input  start, eot, exp_data, exp_vld, dut_data, dut_vld,
        output busy, done, pass, cmp_cnt, mis_cnt, vmis_cnt,
               first_idx, first_exp, first_dut
    );
endinterface

// File: rtl/hd_scoreboard.sv
// Checker for the Hamming encode/decode chain: compares reference and decoded words each cycle,
// counts compares/mismatches/valid misalignments, captures the first bad word, gives a verdict.
module hd_scoreboard #(
    parameter int K     = 8,
    parameter int CNT_W = 16,
    parameter int DRAIN = 4
) (
    input  logic           clk,
    input  logic           rst,
    hd_scoreboard_if.slave sb
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int               DW         = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN - 1);

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [CNT_W-1:0] mis_q, mis_d;
    logic [CNT_W-1:0] vmis_q, vmis_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic [K-1:0]     fexp_q, fexp_d;
    logic [K-1:0]     fdut_q, fdut_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    // Result of checking this cycle's inputs; only committed while in RUN or DRAIN.
    logic [CNT_W-1:0] cmp_upd, mis_upd, vmis_upd, fidx_upd;
    logic [K-1:0]     fexp_upd, fdut_upd;

    always_comb begin
        cmp_upd  = cmp_q;
        mis_upd  = mis_q;
        vmis_upd = vmis_q;
        fidx_upd = fidx_q;
        fexp_upd = fexp_q;
        fdut_upd = fdut_q;
        if (sb.exp_vld && sb.dut_vld) begin
            if (cmp_q != CNT_MAX) begin
                cmp_upd = cmp_q + 1'b1;
            end
            if (sb.exp_data != sb.dut_data) begin
                // mis_q saturates instead of wrapping, so zero means no mismatch seen yet
                if (mis_q == '0) begin
                    fidx_upd = cmp_q;
                    fexp_upd = sb.exp_data;
                    fdut_upd = sb.dut_data;
                end
                if (mis_q != CNT_MAX) begin
                    mis_upd = mis_q + 1'b1;
                end
            end
        end else if (sb.exp_vld != sb.dut_vld) begin
            if (vmis_q != CNT_MAX) begin
                vmis_upd = vmis_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cmp_d   = cmp_q;
        mis_d   = mis_q;
        vmis_d  = vmis_q;
        fidx_d  = fidx_q;
        fexp_d  = fexp_q;
        fdut_d  = fdut_q;
        pass_d  = pass_q;
        if (sb.start) begin
            // start overrides everything, including a coincident eot
            state_d = ST_RUN;
            drain_d = '0;
            cmp_d   = '0;
            mis_d   = '0;
            vmis_d  = '0;
            fidx_d  = '0;
            fexp_d  = '0;
            fdut_d  = '0;
            pass_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    cmp_d  = cmp_upd;
                    mis_d  = mis_upd;
                    vmis_d = vmis_upd;
                    fidx_d = fidx_upd;
                    fexp_d = fexp_upd;
                    fdut_d = fdut_upd;
                    if (sb.eot) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    cmp_d  = cmp_upd;
                    mis_d  = mis_upd;
                    vmis_d = vmis_upd;
                    fidx_d = fidx_upd;
                    fexp_d = fexp_upd;
                    fdut_d = fdut_upd;
                    if (drain_q == '0) begin
                        // verdict includes the last drain cycle's compare
                        state_d = ST_DONE;
                        pass_d  = (cmp_upd != '0) && (mis_upd == '0) && (vmis_upd == '0);
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            cmp_q   <= '0;
            mis_q   <= '0;
            vmis_q  <= '0;
            fidx_q  <= '0;
            fexp_q  <= '0;
            fdut_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cmp_q   <= cmp_d;
            mis_q   <= mis_d;
            vmis_q  <= vmis_d;
            fidx_q  <= fidx_d;
            fexp_q  <= fexp_d;
            fdut_q  <= fdut_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign sb.busy      = busy_q;
    assign sb.done      = done_q;
    assign sb.pass      = pass_q;
    assign sb.cmp_cnt   = cmp_q;
    assign sb.mis_cnt   = mis_q;
    assign sb.vmis_cnt  = vmis_q;
    assign sb.first_idx = fidx_q;
    assign sb.first_exp = fexp_q;
    assign sb.first_dut = fdut_q;
endmodule

// File: tb/tb_hd_scoreboard.sv
// Randomized bench for hd_scoreboard: two builds (16-bit and 4-bit counters) share one stimulus;
// verdicts are predicted from a per-cycle vector list and checked by a done-triggered monitor.
module tb_hd_scoreboard;
    localparam int K      = 8;
    localparam int DRAIN  = 4;
    localparam int CW_BIG = 16;
    localparam int CW_SML = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hd_scoreboard_if #(.K(K), .CNT_W(CW_BIG)) bus_big ();
    hd_scoreboard_if #(.K(K), .CNT_W(CW_SML)) bus_sml ();

    hd_scoreboard #(.K(K), .CNT_W(CW_BIG), .DRAIN(DRAIN)) dut_big (
        .clk(clk), .rst(rst), .sb(bus_big)
    );
    hd_scoreboard #(.K(K), .CNT_W(CW_SML), .DRAIN(DRAIN)) dut_sml (
        .clk(clk), .rst(rst), .sb(bus_sml)
    );

    logic         start_r = 1'b0, eot_r = 1'b0, ev_r = 1'b0, dv_r = 1'b0;
    logic [K-1:0] ed_r = '0, dd_r = '0;
    assign bus_big.start = start_r;  assign bus_sml.start = start_r;
    assign bus_big.eot = eot_r;      assign bus_sml.eot = eot_r;
    assign bus_big.exp_vld = ev_r;   assign bus_sml.exp_vld = ev_r;
    assign bus_big.dut_vld = dv_r;   assign bus_sml.dut_vld = dv_r;
    assign bus_big.exp_data = ed_r;  assign bus_sml.exp_data = ed_r;
    assign bus_big.dut_data = dd_r;  assign bus_sml.dut_data = dd_r;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cmp, mis, vmis, fidx, fexp, fdut, pass, busy, done, done_cyc;
    } res_t;

    res_t q_big[$];
    res_t q_sml[$];

    // Per-cycle stimulus of one run (cycles after the start cycle); eot rides on word n_words-1.
    bit           v_ev[$], v_dv[$];
    logic [K-1:0] v_ed[$], v_dd[$];
    int           n_words;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input res_t a, input res_t e);
        check({tag, ".cmp_cnt"}, a.cmp, e.cmp);
        check({tag, ".mis_cnt"}, a.mis, e.mis);
        check({tag, ".vmis_cnt"}, a.vmis, e.vmis);
        check({tag, ".first_idx"}, a.fidx, e.fidx);
        check({tag, ".first_exp"}, a.fexp, e.fexp);
        check({tag, ".first_dut"}, a.fdut, e.fdut);
        check({tag, ".pass"}, a.pass, e.pass);
        check({tag, ".busy"}, a.busy, e.busy);
        check({tag, ".done"}, a.done, e.done);
    endtask

    function automatic res_t get_big();
        res_t r = '{default: 0};
        r.cmp  = int'(bus_big.cmp_cnt);   r.mis  = int'(bus_big.mis_cnt);
        r.vmis = int'(bus_big.vmis_cnt);  r.fidx = int'(bus_big.first_idx);
        r.fexp = int'(bus_big.first_exp); r.fdut = int'(bus_big.first_dut);
        r.pass = int'(bus_big.pass);      r.busy = int'(bus_big.busy);
        r.done = int'(bus_big.done);      r.done_cyc = cyc;
        return r;
    endfunction

    function automatic res_t get_sml();
        res_t r = '{default: 0};
        r.cmp  = int'(bus_sml.cmp_cnt);   r.mis  = int'(bus_sml.mis_cnt);
        r.vmis = int'(bus_sml.vmis_cnt);  r.fidx = int'(bus_sml.first_idx);
        r.fexp = int'(bus_sml.first_exp); r.fdut = int'(bus_sml.first_dut);
        r.pass = int'(bus_sml.pass);      r.busy = int'(bus_sml.busy);
        r.done = int'(bus_sml.done);      r.done_cyc = cyc;
        return r;
    endfunction

    // Reference: walk every checked cycle and apply the counting rules with a saturation ceiling.
    function automatic res_t model(input int maxv);
        res_t e = '{default: 0};
        for (int i = 0; i < v_ev.size(); i++) begin
            if (v_ev[i] && v_dv[i]) begin
                if (v_ed[i] != v_dd[i]) begin
                    if (e.mis == 0) begin
                        e.fidx = e.cmp;
                        e.fexp = int'(v_ed[i]);
                        e.fdut = int'(v_dd[i]);
                    end
                    e.mis = (e.mis < maxv) ? e.mis + 1 : maxv;
                end
                e.cmp = (e.cmp < maxv) ? e.cmp + 1 : maxv;
            end else if (v_ev[i] != v_dv[i]) begin
                e.vmis = (e.vmis < maxv) ? e.vmis + 1 : maxv;
            end
        end
        e.pass = (e.cmp != 0 && e.mis == 0 && e.vmis == 0) ? 1 : 0;
        e.done = 1;
        return e;
    endfunction

    task automatic clear_vec();
        v_ev.delete(); v_dv.delete(); v_ed.delete(); v_dd.delete();
    endtask

    task automatic push_vec(input bit ev, input logic [K-1:0] ed, input bit dv, input logic [K-1:0] dd);
        v_ev.push_back(ev); v_ed.push_back(ed); v_dv.push_back(dv); v_dd.push_back(dd);
    endtask

    task automatic pad_drain_idle();
        for (int i = 0; i < DRAIN; i++) push_vec(1'b0, '0, 1'b0, '0);
    endtask

    task automatic run(input string tag, input bit collide);
        res_t eb, es, zero;
        eb = model((1 << CW_BIG) - 1);
        es = model((1 << CW_SML) - 1);
        zero = '{default: 0};
        zero.busy = 1;
        @(posedge clk); #1;
        // start-cycle data is a deliberate mismatch that must be discarded
        start_r = 1'b1; eot_r = collide; ev_r = 1'b1; dv_r = 1'b1;
        ed_r = K'($urandom); dd_r = ed_r ^ 8'h5A;
        @(posedge clk); #1;
        start_r = 1'b0;
        check_state({tag, ".clr_big"}, get_big(), zero);
        check_state({tag, ".clr_sml"}, get_sml(), zero);
        for (int i = 0; i < v_ev.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            ev_r = v_ev[i]; dv_r = v_dv[i]; ed_r = v_ed[i]; dd_r = v_dd[i];
            eot_r = (i == n_words - 1);
            if (i == n_words - 1) begin
                eb.done_cyc = cyc + 1 + DRAIN;
                es.done_cyc = eb.done_cyc;
                q_big.push_back(eb);
                q_sml.push_back(es);
            end
        end
        @(posedge clk); #1;
        ev_r = 1'b0; dv_r = 1'b0; eot_r = 1'b0;
        for (int t = 0; t < 40 && (q_big.size() != 0 || q_sml.size() != 0); t++) @(negedge clk);
        check({tag, ".done_timeout"}, q_big.size() + q_sml.size(), 0);
        q_big.delete();
        q_sml.delete();
        $display("run %s: words=%0d exp cmp=%0d mis=%0d vmis=%0d pass=%0d | 4-bit cmp=%0d pass=%0d",
                 tag, n_words, eb.cmp, eb.mis, eb.vmis, eb.pass, es.cmp, es.pass);
    endtask

    // Monitor: each rising done pops one predicted verdict per build.
    logic done_big_prev = 1'b0, done_sml_prev = 1'b0;
    always @(negedge clk) begin
        res_t e;
        check("pass_without_done_big", int'(bus_big.pass & ~bus_big.done), 0);
        check("pass_without_done_sml", int'(bus_sml.pass & ~bus_sml.done), 0);
        if (bus_big.done && !done_big_prev) begin
            if (q_big.size() == 0) begin
                check("unexpected_done_big", q_big.size(), 1);
            end else begin
                e = q_big.pop_front();
                check_state("verdict_big", get_big(), e);
                check("verdict_big.done_cycle", cyc, e.done_cyc);
            end
        end
        if (bus_sml.done && !done_sml_prev) begin
            if (q_sml.size() == 0) begin
                check("unexpected_done_sml", q_sml.size(), 1);
            end else begin
                e = q_sml.pop_front();
                check_state("verdict_sml", get_sml(), e);
                check("verdict_sml.done_cycle", cyc, e.done_cyc);
            end
        end
        done_big_prev <= bus_big.done;
        done_sml_prev <= bus_sml.done;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        res_t zero;
        zero = '{default: 0};

        // Reset state
        #1;
        check_state("reset_big", get_big(), zero);
        check_state("reset_sml", get_sml(), zero);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        $display("reset released at t=%0t", $time);

        // Valid words and an eot in IDLE must not be counted
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            ev_r = 1'b1; dv_r = (i != 2); ed_r = K'(i); dd_r = K'(i + 1); eot_r = (i == 3);
        end
        @(posedge clk); #1;
        ev_r = 1'b0; dv_r = 1'b0; eot_r = 1'b0;
        check_state("idle_big", get_big(), zero);
        check_state("idle_sml", get_sml(), zero);
        $display("idle words: cmp=%0d vmis=%0d busy=%0d", bus_big.cmp_cnt, bus_big.vmis_cnt, bus_big.busy);

        // 10 matched words
        clear_vec();
        for (int i = 0; i < 10; i++) push_vec(1'b1, K'(i), 1'b1, K'(i));
        n_words = 10;
        pad_drain_idle();
        run("matched10", 1'b0);

        // Word 4 corrupted
        clear_vec();
        for (int i = 0; i < 10; i++) push_vec(1'b1, K'(i), 1'b1, (i == 4) ? 8'h44 : K'(i));
        n_words = 10;
        pad_drain_idle();
        run("corrupt4", 1'b0);

        // dut_vld one cycle late over a 5-word burst
        clear_vec();
        for (int i = 0; i < 7; i++) push_vec(i < 5, K'(i), (i >= 1 && i <= 5), K'(i - 1));
        n_words = 7;
        pad_drain_idle();
        run("late_vld", 1'b0);

        // start/eot collision, 20 matched compares (4-bit build saturates)
        clear_vec();
        for (int i = 0; i < 20; i++) push_vec(1'b1, K'(i * 7), 1'b1, K'(i * 7));
        n_words = 20;
        pad_drain_idle();
        run("collide_sat20", 1'b1);

        // Randomized runs, all starting from DONE
        for (int r = 0; r < 24; r++) begin
            bit ev, dv;
            logic [K-1:0] ed, dd;
            clear_vec();
            n_words = $urandom_range(1, 40);
            for (int i = 0; i < n_words + DRAIN; i++) begin
                ev = ($urandom_range(0, 3) != 0);
                dv = (r % 3 == 2 && $urandom_range(0, 5) == 0) ? ~ev : ev;
                ed = K'($urandom);
                dd = (r % 3 == 1 && $urandom_range(0, 4) == 0) ? ed ^ K'($urandom_range(1, 255)) : ed;
                push_vec(ev, ed, dv, dd);
            end
            run($sformatf("rand%0d", r), r[0]);
        end

        // Reset during DRAIN with three mismatches: everything clears at once, no done
        clear_vec();
        @(posedge clk); #1;
        start_r = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start_r = 1'b0;
            ev_r = 1'b1; dv_r = 1'b1; ed_r = K'(i);
            dd_r = (i == 1 || i == 3 || i == 4) ? K'(i) ^ 8'h80 : K'(i);
            eot_r = (i == 5);
        end
        @(posedge clk); #1;
        ev_r = 1'b0; dv_r = 1'b0; eot_r = 1'b0;
        check("drain_rst.pre_mis", int'(bus_big.mis_cnt), 3);
        check("drain_rst.pre_busy", int'(bus_big.busy), 1);
        #3 rst = 1'b0;
        #1;
        check_state("drain_rst_big", get_big(), zero);
        check_state("drain_rst_sml", get_sml(), zero);
        $display("reset in drain: mis=%0d busy=%0d done=%0d", bus_big.mis_cnt, bus_big.busy, bus_big.done);
        repeat (DRAIN + 3) @(negedge clk);
        check("drain_rst.no_done", int'(bus_big.done | bus_sml.done), 0);
        @(posedge clk); #1 rst = 1'b1;

        // Recovery after reset
        clear_vec();
        for (int i = 0; i < 5; i++) push_vec(1'b1, K'(8'hA0 + i), 1'b1, K'(8'hA0 + i));
        n_words = 5;
        pad_drain_idle();
        run("after_reset", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
